imm_extend_stage: RTL and testbench
===================================

// Module: imm_extend_stage
// PURPOSE
//  Parametrised immediate-generation pipeline stage between ID and EX.
//  Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes.
//  Holds the result in a 2-entry skid buffer with valid/ready handshakes, so ID
//  and EX stall independently. Flush squashes in-flight immediates on a branch
//  redirect.
// PARAMETERS
//  IN_W   16  immediate input width; must be >= 2
//  OUT_W  32  extended output width; must be >= IN_W+2
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      async active-high reset
//  flush      in   1      sync squash of all buffered entries
//  in_valid   in   1      ID presents an immediate
//  in_ready   out  1      stage can accept this cycle
//  in_imm     in   IN_W   raw immediate field
//  in_mode    in   2      00 sext, 01 zext, 10 upper, 11 branch (sext<<2)
//  out_valid  out  1      EX-side entry valid
//  out_ready  in   1      EX consumes this cycle
//  out_imm    out  OUT_W  extended immediate
//  out_mode   out  2      mode that produced out_imm
// BEHAVIOUR
//  - Handshakes: input transfer when in_valid&&in_ready; output transfer when
//    out_valid&&out_ready. Data is captured only on transfer.
//  - Extension, evaluated on the input side before registering:
//    - sext: {{(OUT_W-IN_W){imm[IN_W-1]}}, imm}
//    - zext: {(OUT_W-IN_W)'b0, imm}
//    - upper: imm << (OUT_W-IN_W), low bits zero (LUI)
//    - branch: sext result << 2; the two MSBs shifted out are discarded
//  - Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
//  - Storage: main reg (drives outputs) plus skid reg.
//    - in_ready = !skid_valid && !rst (registered-full, no combinational path
//      from out_ready).
//  - FSM: EMPTY, ONE, FULL.
//    - EMPTY: in xfer -> ONE (main loads).
//    - ONE: in xfer and no out xfer -> FULL (skid loads).
//    - ONE: out xfer and no in xfer -> EMPTY.
//    - ONE: in xfer and out xfer -> ONE (main reloads).
//    - FULL: out xfer -> ONE (main <= skid). in_ready=0 in FULL, so no in xfer.
//  - Ordering is strictly FIFO; no entry is duplicated or dropped without flush.
//  - flush: next state EMPTY. Flush beats any input or output transfer in the
//    same cycle; the input that cycle is discarded. Outputs hold their last
//    data but out_valid=0.
//  - Reset (async, any time, including mid-transfer): state EMPTY,
//    out_valid=0, out_imm=0, out_mode=0, in_ready=0 while rst is high,
//    1 on the first cycle after release.
//  - out_imm and out_mode are stable while out_valid&&!out_ready.
// CONFIGURATION
//  IMMX_STALL_CNT_EN defined:
//    - Adds output stall_cnt [15:0].
//    - Increments each cycle with in_valid&&!in_ready, saturating at 16'hFFFF.
//    - Reset 0; unaffected by flush.
//  Undefined: the port and counter are absent. Datapath behaviour is identical.
// TESTING
//  - Use IN_W=16, OUT_W=32 unless noted.
//  1 sext 16'h8001 -> 32'hFFFF8001; zext 16'h8001 -> 32'h00008001;
//    upper 16'h1234 -> 32'h12340000; branch 16'hFFFF -> 32'hFFFFFFFC;
//    each out_valid one cycle after accept.
//  2 out_ready=0, send 16'h0001, 16'h0002 -> in_ready=0 after 2nd;
//    a 3rd in_valid held; release out_ready -> outputs 1, 2, 3 in order.
//  3 Continuous in_valid and out_ready=1 -> one result per cycle, in_ready
//    never drops, ordering preserved over 100 random immediates.
//  4 FULL state + flush asserted with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, flushed input never appears.
//  5 Assert rst asynchronously mid-stream while FULL -> out_valid=0 and
//    out_imm=0 immediately; no stale entry after release.
//  6 IMMX_STALL_CNT_EN: hold FULL with in_valid=1 for 5 cycles ->
//    stall_cnt=5; force 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate-extension stage between ID and EX with a 2-entry skid buffer.
// Optional stall counter output enabled by defining IMMX_STALL_CNT_EN.
module imm_extend_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [1:0]       out_mode
`ifdef IMMX_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   localparam int PAD_W = OUT_W - IN_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stateT;

   function automatic logic signed [OUT_W-1:0] extendImm(input logic [IN_W-1:0] imm,
                                                        input logic [1:0]      mode);
      logic signed [OUT_W-1:0] sx;
      sx = {{PAD_W{imm[IN_W-1]}}, imm};
      case (mode)
         2'b00:   extendImm = sx;
         2'b01:   extendImm = {{PAD_W{1'b0}}, imm};
         2'b10:   extendImm = {imm, {PAD_W{1'b0}}};
         default: extendImm = sx <<< 2;
      endcase
   endfunction

   function automatic logic [15:0] satInc16(input logic [15:0] cnt);
      satInc16 = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   stateT                   state_p1;
   logic signed [OUT_W-1:0] extImm_p0;
   logic signed [OUT_W-1:0] mainImm_p1;
   logic signed [OUT_W-1:0] skidImm_p1;
   logic [1:0]              mainMode_p1;
   logic [1:0]              skidMode_p1;
   logic                    inXfer;
   logic                    outXfer;
   logic                    loadSkid;

   // Input side: extension is combinational ahead of the buffer registers.
   assign extImm_p0 = extendImm(in_imm, in_mode);

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (state_p1 != FULL) && !rst;
   assign out_valid = (state_p1 != EMPTY);
   assign out_imm   = mainImm_p1;
   assign out_mode  = mainMode_p1;

   assign inXfer   = in_valid && in_ready;
   assign outXfer  = out_valid && out_ready;
   assign loadSkid = !flush && (state_p1 == ONE) && inXfer && !outXfer;

   // Stage p1: occupancy FSM and the main (output-facing) register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1    <= EMPTY;
         mainImm_p1  <= '0;
         mainMode_p1 <= '0;
      end else if (flush) begin
         state_p1 <= EMPTY;
      end else begin
         case (state_p1)
            EMPTY: begin
               if (inXfer) begin
                  mainImm_p1  <= extImm_p0;
                  mainMode_p1 <= in_mode;
                  state_p1    <= ONE;
               end
            end
            ONE: begin
               if (inXfer && outXfer) begin
                  mainImm_p1  <= extImm_p0;
                  mainMode_p1 <= in_mode;
               end else if (inXfer) begin
                  state_p1 <= FULL;
               end else if (outXfer) begin
                  state_p1 <= EMPTY;
               end
            end
            FULL: begin
               if (outXfer) begin
                  mainImm_p1  <= skidImm_p1;
                  mainMode_p1 <= skidMode_p1;
                  state_p1    <= ONE;
               end
            end
            default: state_p1 <= EMPTY;
         endcase
      end
   end

   // Skid data is only meaningful while FULL, so it carries no reset.
   always_ff @(posedge clk) begin
      if (loadSkid) begin
         skidImm_p1  <= extImm_p0;
         skidMode_p1 <= in_mode;
      end
   end

`ifdef IMMX_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready) begin
         stall_cnt <= satInc16(stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage with a queue scoreboard on the output side.
module tb_imm_extend_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [1:0]  out_mode;
`ifdef IMMX_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [33:0] sb[$];

   imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_mode  (out_mode)
`ifdef IMMX_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
      logic [31:0] s;
      s = {{16{imm[15]}}, imm};
      case (mode)
         2'b00:   model = s;
         2'b01:   model = {16'h0000, imm};
         2'b10:   model = {imm, 16'h0000};
         default: model = {s[29:0], 2'b00};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: sample at negedge what the next rising edge will transfer.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_out", {30'd0, out_valid, 1'b0}, 32'd0);
            end else begin
               chk("sb_imm", out_imm, sb[0][31:0]);
               chk("sb_mode", {30'd0, out_mode}, {30'd0, sb[0][33:32]});
               void'(sb.pop_front());
            end
         end
         if (in_valid && in_ready) sb.push_back({in_mode, model(in_imm, in_mode)});
      end
   end

   // Present one immediate and hold it until the stage accepts it.
   task automatic sendWait(input logic [15:0] imm, input logic [1:0] mode);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic drain();
      logic done;
      done      = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk);
         #1;
         done = !out_valid;
      end
      chk("drain_timeout", {31'd0, done}, 32'd1);
      chk("sb_empty", sb.size(), 32'd0);
   endtask

   initial begin
      logic [15:0] vImm[4];
      logic [31:0] vExp[4];
      int          drops;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_mode", {30'd0, out_mode}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Four modes, each visible one cycle after acceptance.
      vImm = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
      vExp = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC};
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         sendWait(vImm[m], m[1:0]);
         chk("t1_valid", {31'd0, out_valid}, 32'd1);
         chk("t1_imm", out_imm, vExp[m]);
         chk("t1_mode", {30'd0, out_mode}, m);
         @(posedge clk); #1;
         chk("t1_consumed", {31'd0, out_valid}, 32'd0);
      end

      // Back-pressure fills the buffer; a third input waits.
      out_ready = 1'b0;
      sendWait(16'h0001, 2'b00);
      chk("t2_ready_one", {31'd0, in_ready}, 32'd1);
      sendWait(16'h0002, 2'b00);
      chk("t2_ready_full", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_imm = 16'h0003; in_mode = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("t2_held_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_stable_imm", out_imm, 32'h00000001);
      out_ready = 1'b1;
      sendWait(16'h0003, 2'b00);
      drain();

      // Streaming at full rate.
      drops = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_imm  = 16'($urandom);
         in_mode = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (!in_ready) drops++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("t3_in_ready_drops", drops, 32'd0);
      chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
      drain();

      // Flush while FULL, with a competing input.
      out_ready = 1'b0;
      sendWait(16'h0011, 2'b01);
      sendWait(16'h0022, 2'b01);
      in_valid = 1'b1; in_imm = 16'hDEAD; in_mode = 2'b00; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t4_hold_imm", out_imm, 32'h00000011);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_no_ghost", {31'd0, out_valid}, 32'd0);
      sendWait(16'h7FFF, 2'b11);
      drain();

      // Asynchronous reset mid-stream while FULL.
      out_ready = 1'b0;
      sendWait(16'h0101, 2'b10);
      sendWait(16'h0202, 2'b10);
      #1 rst = 1'b1;
      #1;
      chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_out_imm", out_imm, 32'd0);
      chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("t5_ready_after", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
      sendWait(16'h4321, 2'b00);
      drain();

`ifdef IMMX_STALL_CNT_EN
      #1 rst = 1'b1;
      #1;
      chk("t6_cnt_rst", {16'd0, stall_cnt}, 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      sendWait(16'h0005, 2'b00);
      sendWait(16'h0006, 2'b00);
      in_valid = 1'b1; in_imm = 16'h0007;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_cnt5", {16'd0, stall_cnt}, 32'd5);
      repeat (70000) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t6_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
